// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_pkg
//  Brief    : Shared word width, opcode set and queue entry type for fetch.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  localparam int WORD = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_LD  = 4'h8,
    OP_ST  = 4'h9,
    OP_MOV = 4'hA,
    OP_JZ  = 4'hB,
    OP_SYS = 4'hC,
    OP_SZ  = 4'hD,
    OP_NOP = 4'hE,
    OP_LI  = 4'hF
  } opcode_e;

  localparam opcode_e LI_OPCODE = OP_LI;

  // Field slice positions: op [15:12], src [11:6], dst [5:0].
  typedef struct packed {
    opcode_e    op;
    logic [5:0] src;
    logic [5:0] dst;
  } inst_t;

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Brief    : Power-of-two FIFO of {pc, inst} with flush, 0/1/2-entry pop and
//             a head+1 peek used for LI fusing.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t pushEntry,
  input  logic [1:0]   popCount,
  output fetch_entry_t headEntry,
  output fetch_entry_t nextEntry,
  output logic [CW-1:0] count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clock) begin
    if (push && !reset && !flush) begin
      r_mem[r_wrPtr] <= pushEntry;
    end
  end

  // Flush wins over a same-cycle push: that word belongs to the old stream.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      r_rdPtr <= r_rdPtr + AW'(popCount);
      r_count <= r_count + CW'(push) - CW'(popCount);
      assert (!(push && r_count == CW'(DEPTH)));
      assert (CW'(popCount) <= r_count);
    end
  end

  assign headEntry = r_mem[r_rdPtr];
  assign nextEntry = r_mem[r_rdPtr + AW'(1)];
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction fetch: PC, 1-cycle imem requests, queue, redirect.
//             Optional LI + immediate fusing when LI_FUSE_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = 16'h0000,
  parameter int              QDEPTH   = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic [WORD-1:0] imem_data,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_inst,
  output logic [WORD-1:0] out_pc,
  output logic [WORD-1:0] out_imm,
  output logic            out_has_imm
);

  localparam int               c_countW = $clog2(QDEPTH + 1);
  localparam logic [c_countW:0] c_depth = (c_countW + 1)'(QDEPTH);

  logic [WORD-1:0]     r_fetchPc;
  logic                r_inflight;
  logic [WORD-1:0]     r_inflightPc;
  logic [c_countW-1:0] w_count;
  logic [c_countW:0]   w_used;
  logic                w_push;
  fetch_entry_t        w_pushEntry;
  fetch_entry_t        w_head;
  fetch_entry_t        w_next;
  logic [1:0]          w_popCount;
  logic                w_unused;

  // Credits cover both queued words and the one still in the memory pipe.
  assign w_used    = {1'b0, w_count} + {{c_countW{1'b0}}, r_inflight};
  assign imem_req  = !reset && !redirect && (w_used < c_depth);
  assign imem_addr = r_fetchPc;

  assign w_push      = r_inflight && !redirect;
  assign w_pushEntry = '{pc: r_inflightPc, inst: imem_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetchPc    <= RESET_PC;
      r_inflight   <= 1'b0;
      r_inflightPc <= '0;
    end else begin
      r_inflight   <= imem_req;
      r_inflightPc <= r_fetchPc;
      if (redirect) begin
        r_fetchPc <= redirect_pc;
      end else if (imem_req) begin
        r_fetchPc <= r_fetchPc + 16'd1;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (w_push),
    .pushEntry (w_pushEntry),
    .popCount  (w_popCount),
    .headEntry (w_head),
    .nextEntry (w_next),
    .count     (w_count)
  );

`ifdef LI_FUSE_EN
  inst_t w_headInst;
  logic  w_headIsLi;

  assign w_headInst = w_head.inst;
  assign w_headIsLi = (w_headInst.op == LI_OPCODE);
  assign w_unused   = ^{w_next.pc};

  // An LI is held back until its immediate word has also been queued.
  always_comb begin
    out_inst    = '0;
    out_pc      = '0;
    out_imm     = '0;
    out_has_imm = 1'b0;
    w_popCount  = 2'd0;
    out_valid   = (w_count != '0) && (!w_headIsLi || w_count > c_countW'(1));
    if (out_valid) begin
      out_inst = w_head.inst;
      out_pc   = w_head.pc;
      if (w_headIsLi) begin
        out_imm     = w_next.inst;
        out_has_imm = 1'b1;
      end
      if (out_ready) begin
        w_popCount = w_headIsLi ? 2'd2 : 2'd1;
      end
    end
  end
`else
  assign w_unused = ^{w_next};

  always_comb begin
    out_inst    = '0;
    out_pc      = '0;
    out_imm     = '0;
    out_has_imm = 1'b0;
    out_valid   = (w_count != '0);
    w_popCount  = {1'b0, out_valid && out_ready};
    if (out_valid) begin
      out_inst = w_head.inst;
      out_pc   = w_head.pc;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Directed + random bench for fetch_unit with a program-order model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0010;
  localparam int          QD     = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] imem_data = '0;
  logic        imem_req, out_valid, out_has_imm;
  logic [15:0] imem_addr, out_inst, out_pc, out_imm;

  logic [15:0] mem [65536];

  int          compared = 0;
  int          mismatched = 0;

  // Model state: the accepted stream must be program order from the last restart.
  logic [15:0] expPc, expReqPc, lastPc, lastInst, lastImm, prevXferPc;
  logic        lastHas, prevFlush, sawWrap;
  int          reqCnt, popCnt, xferCount, totalReq;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .QDEPTH   (QD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_has_imm (out_has_imm)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (imem_req) imem_data <= mem[imem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic        fuse;
    logic        expReq;
    logic [15:0] nxt;
    int          words;
    @(negedge clock);
    if (reset) begin
      chk("req_in_reset", {31'd0, imem_req}, 32'd0);
      expPc = RST_PC; expReqPc = RST_PC; reqCnt = 0; popCnt = 0; prevFlush = 1'b1;
    end else begin
      expReq = !redirect && ((reqCnt - popCnt) < QD);
      chk("imem_req", {31'd0, imem_req}, {31'd0, expReq});
      if (imem_req) begin
        totalReq++;
        chk("imem_addr", {16'd0, imem_addr}, {16'd0, expReqPc});
      end
      if (prevFlush) chk("valid_after_flush", {31'd0, out_valid}, 32'd0);
      words = 0;
      if (out_valid && out_ready) begin
        nxt = expPc + 16'd1;
`ifdef LI_FUSE_EN
        fuse = (mem[expPc][15:12] == 4'hF);
`else
        fuse = 1'b0;
`endif
        chk("out_pc", {16'd0, out_pc}, {16'd0, expPc});
        chk("out_inst", {16'd0, out_inst}, {16'd0, mem[expPc]});
        chk("out_has_imm", {31'd0, out_has_imm}, {31'd0, fuse});
        chk("out_imm", {16'd0, out_imm}, {16'd0, (fuse ? mem[nxt] : 16'h0000)});
        words = fuse ? 2 : 1;
        xferCount++;
        lastPc = out_pc; lastInst = out_inst; lastImm = out_imm; lastHas = out_has_imm;
        if (prevXferPc == 16'hFFFF && out_pc == 16'h0000) sawWrap = 1'b1;
        prevXferPc = out_pc;
      end
      if (redirect) begin
        expPc = redirect_pc; expReqPc = redirect_pc; reqCnt = 0; popCnt = 0; prevFlush = 1'b1;
      end else begin
        if (expReq) begin
          expReqPc = expReqPc + 16'd1;
          reqCnt++;
        end
        popCnt += words;
        expPc = expPc + 16'(words);
        prevFlush = 1'b0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic waitXfer(input string tag);
    int n0;
    n0 = xferCount;
    for (int i = 0; i < 30; i++) begin
      step();
      if (xferCount != n0) break;
    end
    chk(tag, xferCount, n0 + 1);
  endtask

  initial begin
    int n0;
    int r0;
    expPc = RST_PC; expReqPc = RST_PC; reqCnt = 0; popCnt = 0; prevFlush = 1'b1;
    xferCount = 0; totalReq = 0; sawWrap = 1'b0; prevXferPc = 16'h1234;
    lastPc = '0; lastInst = '0; lastImm = '0; lastHas = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    for (int a = 0; a < 8; a++) mem[a] = {4'h0, 12'($urandom)};
    for (int a = 16'h10; a < 16'h20; a++) mem[a] = {4'h0, 12'($urandom)};
    for (int a = 16'h22; a < 16'h30; a++) mem[a] = {4'h1, 12'($urandom)};
    for (int a = 16'hFFF8; a < 65536; a++) mem[a] = {4'h2, 12'($urandom)};
    mem[16'h0020] = 16'hF005;
    mem[16'h0021] = 16'h1234;

    // Reset state
    step(); step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_has_imm", {31'd0, out_has_imm}, 32'd0);
    chk("rst_inst", {16'd0, out_inst}, 32'd0);
    chk("rst_pc", {16'd0, out_pc}, 32'd0);
    chk("rst_imm", {16'd0, out_imm}, 32'd0);

    // Startup latency and streaming from RESET_PC
    reset = 1'b0; out_ready = 1'b1;
    step();
    chk("lat_c1_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_c2_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_c2_pc", {16'd0, out_pc}, 32'h0010);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
    end

    // Back-pressure: only QDEPTH words outstanding
    out_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0000;
    step();
    redirect = 1'b0;
    r0 = totalReq;
    for (int i = 0; i < 10; i++) step();
    chk("stall_req_count", totalReq - r0, 4);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_pc", {16'd0, out_pc}, 32'h0000);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Redirect with 3 queued entries and one request in flight
    out_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_redir_pc", {16'd0, out_pc}, 32'h0040);
    redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0; out_ready = 1'b1;
    waitXfer("redir_timeout");
    chk("redir_first_pc", {16'd0, lastPc}, 32'h0100);

    // PC wrap FFFF -> 0000
    redirect = 1'b1; redirect_pc = 16'hFFFD; sawWrap = 1'b0;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("wrap_seen", {31'd0, sawWrap}, 32'd1);

    // LI word followed by its immediate
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    waitXfer("li_timeout");
    chk("li_pc", {16'd0, lastPc}, 32'h0020);
    chk("li_inst", {16'd0, lastInst}, 32'hF005);
`ifdef LI_FUSE_EN
    chk("li_has_imm", {31'd0, lastHas}, 32'd1);
    chk("li_imm", {16'd0, lastImm}, 32'h1234);
    waitXfer("li_next_timeout");
    chk("li_next_pc", {16'd0, lastPc}, 32'h0022);
`else
    chk("li_has_imm", {31'd0, lastHas}, 32'd0);
    chk("li_imm", {16'd0, lastImm}, 32'h0000);
    waitXfer("li_next_timeout");
    chk("li_next_pc", {16'd0, lastPc}, 32'h0021);
    chk("li_next_inst", {16'd0, lastInst}, 32'h1234);
`endif

    // Redirect in the same cycle as an accepted transfer
    for (int i = 0; i < 10; i++) begin
      if (out_valid) break;
      step();
    end
    chk("rx_pre_valid", {31'd0, out_valid}, 32'd1);
    redirect = 1'b1; redirect_pc = 16'h0200;
    n0 = xferCount;
    step();
    chk("rx_xfer_counted", xferCount, n0 + 1);
    redirect = 1'b0;
    chk("rx_bubble", {31'd0, out_valid}, 32'd0);
    step();

    // Random traffic with redirects and occasional mid-run reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1; out_ready = 1'b0; redirect = 1'b0;
        step(); step();
        reset = 1'b0;
      end
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                : 16'($urandom);
      step();
    end
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
